// File: rtl/ffo32_scan_sequencer.sv
// Walks every set bit of a word through the sequential 32-bit find-first-one engine.
// Define FFO_SEQ_STATS_EN to add the hit_count output.
module ffo32_scan_sequencer #(
    parameter int MAX_HITS = 32
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        vec_valid,
    input  logic [0:31] vec_in,
    output logic        vec_ready,
    output logic        ffo_start,
    output logic [0:31] ffo_b,
    input  logic        ffo_v,
    input  logic [4:0]  ffo_p,
    input  logic        ffo_ready,
    output logic        idx_valid,
    output logic [4:0]  idx,
    input  logic        idx_ready,
    output logic        word_done
`ifdef FFO_SEQ_STATS_EN
    ,
    output logic [5:0]  hit_count
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        EMIT,
        DONE
    } state_t;

    localparam logic [5:0] MAX = 6'(MAX_HITS);

    state_t      state;
    logic [0:31] w;
    logic [5:0]  hits;

    assign vec_ready = (state == IDLE);
    assign ffo_start = (state == LAUNCH);
    assign idx_valid = (state == EMIT);
    assign word_done = (state == DONE);
    assign ffo_b     = w;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            w     <= '0;
            hits  <= '0;
            idx   <= '0;
`ifdef FFO_SEQ_STATS_EN
            hit_count <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (vec_valid) begin
                        w    <= vec_in;
                        hits <= '0;
                        if (vec_in != '0) begin
                            state <= LAUNCH;
                        end else begin
                            state <= DONE;
`ifdef FFO_SEQ_STATS_EN
                            hit_count <= '0;
`endif
                        end
                    end
                end
                LAUNCH: state <= WAIT;
                WAIT: begin
                    if (ffo_ready) begin
                        if (ffo_v) begin
                            idx      <= ffo_p;
                            w[ffo_p] <= 1'b0;
                            if (hits != MAX) begin
                                hits <= hits + 6'd1;
                            end
                            state <= EMIT;
                        end else begin
                            // engine found nothing although W was nonzero
                            state <= DONE;
`ifdef FFO_SEQ_STATS_EN
                            hit_count <= hits;
`endif
                        end
                    end
                end
                EMIT: begin
                    if (idx_ready) begin
                        if (w == '0 || hits >= MAX) begin
                            state <= DONE;
`ifdef FFO_SEQ_STATS_EN
                            hit_count <= hits;
`endif
                        end else begin
                            state <= LAUNCH;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ffo32_scan_sequencer.sv
// Scoreboard bench: instance 0 uses MAX_HITS=32, instance 1 MAX_HITS=4,
// each driven by a behavioural sequential find-first-one engine.
module tb_ffo32_scan_sequencer;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [1:0]  vec_valid;
    logic [0:31] vec_in [2];
    logic [1:0]  vec_ready;
    logic [1:0]  ffo_start;
    logic [0:31] ffo_b [2];
    logic [1:0]  ffo_v;
    logic [4:0]  ffo_p [2];
    logic [1:0]  ffo_ready;
    logic [1:0]  idx_valid;
    logic [4:0]  idx [2];
    logic [1:0]  idx_ready;
    logic [1:0]  word_done;
`ifdef FFO_SEQ_STATS_EN
    logic [5:0]  hit_count [2];
`endif

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [5:0] busy;
        logic       ev;
        logic [4:0] ep;

        ffo32_scan_sequencer #(.MAX_HITS(g == 0 ? 32 : 4)) dut (
            .clock     (clock),
            .reset_n   (reset_n),
            .vec_valid (vec_valid[g]),
            .vec_in    (vec_in[g]),
            .vec_ready (vec_ready[g]),
            .ffo_start (ffo_start[g]),
            .ffo_b     (ffo_b[g]),
            .ffo_v     (ffo_v[g]),
            .ffo_p     (ffo_p[g]),
            .ffo_ready (ffo_ready[g]),
            .idx_valid (idx_valid[g]),
            .idx       (idx[g]),
            .idx_ready (idx_ready[g]),
            .word_done (word_done[g])
`ifdef FFO_SEQ_STATS_EN
            ,
            .hit_count (hit_count[g])
`endif
        );

        // engine: busy for k+1 cycles after start, k = first set index
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                busy <= '0;
                ev   <= 1'b0;
                ep   <= '0;
            end else if (ffo_start[g]) begin
                busy <= 6'd32;
                ev   <= 1'b0;
                ep   <= '0;
                for (int k = 31; k >= 0; k--) begin
                    if (ffo_b[g][k]) begin
                        busy <= 6'(k + 1);
                        ev   <= 1'b1;
                        ep   <= 5'(k);
                    end
                end
            end else if (busy != '0) begin
                busy <= busy - 6'd1;
            end
        end

        assign ffo_v[g]     = ev;
        assign ffo_p[g]     = ep;
        assign ffo_ready[g] = (busy == '0);
    end

    typedef struct {
        int inst;
        bit done;
        int val;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int passed = 0;
    int starts [2];
    int first_iv [2];
    int hs_cyc [2];
    int acc_cyc;
    int done_at;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endfunction

    task automatic push(input int g, input bit d, input int v);
        exp_t e;
        e.inst = g;
        e.done = d;
        e.val  = v;
        q.push_back(e);
    endtask

    task automatic pop_check(input int g, input bit d, input int val);
        exp_t e;
        bit ok;
        checks++;
        if (q.size() == 0) begin
            $display("FAIL out%0d unexpected: got done=%0d val=%0d, expected nothing",
                     g, d, val);
            return;
        end
        e = q.pop_front();
`ifdef FFO_SEQ_STATS_EN
        ok = (e.inst == g) && (e.done == d) && (e.val == val);
`else
        ok = (e.inst == g) && (e.done == d) && (d || e.val == val);
`endif
        if (ok) passed++;
        else $display("FAIL out%0d: got done=%0d val=%0d, expected inst=%0d done=%0d val=%0d",
                      g, d, val, e.inst, e.done, e.val);
    endtask

    // monitor
    always @(negedge clock) begin
        if (reset_n) begin
            for (int g = 0; g < 2; g++) begin
                int hv;
                if (ffo_start[g]) starts[g]++;
                if (idx_valid[g] && first_iv[g] < 0) first_iv[g] = cyc;
                if (idx_valid[g] && idx_ready[g]) begin
                    hs_cyc[g] = cyc;
                    pop_check(g, 1'b0, int'(idx[g]));
                end
                if (word_done[g]) begin
`ifdef FFO_SEQ_STATS_EN
                    hv = int'(hit_count[g]);
`else
                    hv = -1;
`endif
                    pop_check(g, 1'b1, hv);
                end
            end
        end
    end

    task automatic send(input int g, input logic [0:31] w);
        bit got;
        got = 1'b0;
        starts[g] = 0;
        first_iv[g] = -1;
        @(posedge clock) #1;
        vec_in[g] = w;
        vec_valid[g] = 1'b1;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clock);
            if (vec_ready[g]) begin
                acc_cyc = cyc;
                got = 1'b1;
            end
        end
        if (!got) chk("accept_timeout", 0, 1);
        @(posedge clock) #1;
        vec_valid[g] = 1'b0;
    endtask

    task automatic wait_done(input int g, input int bound);
        bit got;
        got = 1'b0;
        for (int n = 0; n < bound && !got; n++) begin
            @(negedge clock);
            if (word_done[g]) begin
                done_at = cyc;
                got = 1'b1;
            end
        end
        if (!got) chk("done_timeout", 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [0:31] w;
        int bad;
        int s0;
        vec_valid = '0;
        idx_ready = 2'b11;
        vec_in[0] = '0;
        vec_in[1] = '0;
        starts[0] = 0;
        starts[1] = 0;
        first_iv[0] = -1;
        first_iv[1] = -1;
        hs_cyc[0] = 0;
        hs_cyc[1] = 0;
        acc_cyc = 0;
        done_at = 0;

        #12;
        chk("rst_vec_ready", int'(vec_ready), 3);
        chk("rst_start_iv_done", int'({ffo_start, idx_valid, word_done}), 0);
        chk("rst_idx", int'(idx[0]), 0);
        chk("rst_ffo_b", int'(ffo_b[0] != '0), 0);
        @(posedge clock) #1;
        reset_n = 1'b1;

        // zero word
        push(0, 1'b1, 0);
        send(0, 32'h0);
        wait_done(0, 10);
        chk("zero_starts", starts[0], 0);
        chk("zero_no_idx", first_iv[0], -1);
        bad = ((done_at - acc_cyc) >= 1 && (done_at - acc_cyc) <= 2) ? 0 : 1;
        chk("zero_done_lat", bad, 0);

        // bit 0 only
        push(0, 1'b0, 0);
        push(0, 1'b1, 1);
        send(0, 32'h8000_0000);
        wait_done(0, 20);
        chk("bit0_lat", first_iv[0] - acc_cyc, 4);
        chk("bit0_done_after_hs", done_at - hs_cyc[0], 1);

        // bit 31 only
        push(0, 1'b0, 31);
        push(0, 1'b1, 1);
        send(0, 32'h0000_0001);
        wait_done(0, 60);
        chk("bit31_lat", first_iv[0] - acc_cyc, 35);
        chk("bit31_done_after_hs", done_at - hs_cyc[0], 1);

        // bits 3, 10, 31
        w = '0;
        w[3] = 1'b1;
        w[10] = 1'b1;
        w[31] = 1'b1;
        push(0, 1'b0, 3);
        push(0, 1'b0, 10);
        push(0, 1'b0, 31);
        push(0, 1'b1, 3);
        send(0, w);
        wait_done(0, 200);
        chk("three_starts", starts[0], 3);

        // all ones, MAX_HITS=4
        for (int k = 0; k < 4; k++) push(1, 1'b0, k);
        push(1, 1'b1, 4);
        send(1, 32'hFFFF_FFFF);
        wait_done(1, 100);
        chk("max_starts", starts[1], 4);
        @(negedge clock);
        chk("max_vec_ready", int'(vec_ready[1]), 1);

        // backpressure
        w = '0;
        w[5] = 1'b1;
        w[7] = 1'b1;
        idx_ready[0] = 1'b0;
        push(0, 1'b0, 5);
        push(0, 1'b0, 7);
        push(0, 1'b1, 2);
        send(0, w);
        bad = 1;
        for (int n = 0; n < 50 && bad != 0; n++) begin
            @(negedge clock);
            if (idx_valid[0]) bad = 0;
        end
        chk("bp_valid_seen", bad, 0);
        chk("bp_idx", int'(idx[0]), 5);
        s0 = starts[0];
        for (int n = 0; n < 10; n++) begin
            @(negedge clock);
            if (!idx_valid[0] || idx[0] != 5'd5 || vec_ready[0] || ffo_start[0])
                bad++;
        end
        chk("bp_hold", bad, 0);
        chk("bp_no_relaunch", starts[0], s0);
        @(posedge clock) #1;
        idx_ready[0] = 1'b1;
        wait_done(0, 60);

        // reset mid-WAIT
        w = '0;
        w[20] = 1'b1;
        send(0, w);
        repeat (4) @(negedge clock);
        chk("wait_busy", int'(ffo_ready[0]), 0);
        chk("wait_ffo_b", int'(ffo_b[0] == w), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_vec_ready", int'(vec_ready[0]), 1);
        chk("arst_outs", int'({ffo_start[0], idx_valid[0], word_done[0]}), 0);
        chk("arst_idx", int'(idx[0]), 0);
        chk("arst_ffo_b", int'(ffo_b[0] != '0), 0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (30) @(negedge clock);

        // recovery after reset
        w = '0;
        w[2] = 1'b1;
        push(0, 1'b0, 2);
        push(0, 1'b1, 1);
        send(0, w);
        wait_done(0, 30);
        chk("post_rst_lat", first_iv[0] - acc_cyc, 6);

        repeat (5) @(negedge clock);
        chk("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
